// File: rtl/wb_arbiter.sv
// Writeback arbiter: two result queues (ALU, load) merged round-robin onto the register-file port.
// Define WB_ARBITER_STATS_EN to add saturating write/drop counters (wb_cnt, drop_cnt).
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        alu_valid,
    input  logic [4:0]  alu_wa,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_wa,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic [31:0] wr,
    output logic [4:0]  wa,
    output logic        wren,
    output logic [31:0] pend,
    output logic        idle
`ifdef WB_ARBITER_STATS_EN
    ,
    output logic [31:0] wb_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    logic [36:0]   alu_mem [DEPTH];
    logic [36:0]   ld_mem  [DEPTH];
    logic [AW-1:0] alu_wp_q, alu_rp_q, ld_wp_q, ld_rp_q;
    logic [AW:0]   alu_cnt_q, ld_cnt_q;
    logic          last_ld_q;

    logic alu_ne, ld_ne, gnt_alu, gnt_ld;
    logic alu_acc, ld_acc, alu_push, ld_push, alu_drop, ld_drop;

    assign alu_ready = (alu_cnt_q != Full);
    assign ld_ready  = (ld_cnt_q != Full);
    assign alu_acc   = alu_valid & alu_ready;
    assign ld_acc    = ld_valid & ld_ready;
    assign alu_push  = alu_acc & (alu_wa != 5'd0);
    assign ld_push   = ld_acc & (ld_wa != 5'd0);
    assign alu_drop  = alu_acc & (alu_wa == 5'd0);
    assign ld_drop   = ld_acc & (ld_wa == 5'd0);

    assign alu_ne  = (alu_cnt_q != '0);
    assign ld_ne   = (ld_cnt_q != '0);
    // Under contention the source that did not win last time gets the port.
    assign gnt_alu = alu_ne & (~ld_ne | last_ld_q);
    assign gnt_ld  = ld_ne & (~alu_ne | ~last_ld_q);

    assign idle = ~alu_ne & ~ld_ne;

    always_comb begin
        wren = 1'b1;
        wa   = '0;
        wr   = '0;
        if (gnt_ld) begin
            wren     = 1'b0;
            {wa, wr} = ld_mem[ld_rp_q];
        end else if (gnt_alu) begin
            wren     = 1'b0;
            {wa, wr} = alu_mem[alu_rp_q];
        end
    end

    // An slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - alu_rp_q)} < alu_cnt_q) pend[alu_mem[i][36:32]] = 1'b1;
            if ({1'b0, AW'(AW'(i) - ld_rp_q)} < ld_cnt_q) pend[ld_mem[i][36:32]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alu_push) alu_mem[alu_wp_q] <= {alu_wa, alu_data};
        if (ld_push) ld_mem[ld_wp_q] <= {ld_wa, ld_data};
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            alu_wp_q  <= '0;
            alu_rp_q  <= '0;
            alu_cnt_q <= '0;
            ld_wp_q   <= '0;
            ld_rp_q   <= '0;
            ld_cnt_q  <= '0;
            last_ld_q <= 1'b0;
        end else begin
            if (alu_push) alu_wp_q <= alu_wp_q + 1'b1;
            if (gnt_alu) alu_rp_q <= alu_rp_q + 1'b1;
            if (ld_push) ld_wp_q <= ld_wp_q + 1'b1;
            if (gnt_ld) ld_rp_q <= ld_rp_q + 1'b1;
            alu_cnt_q <= alu_cnt_q + {{AW{1'b0}}, alu_push} - {{AW{1'b0}}, gnt_alu};
            ld_cnt_q  <= ld_cnt_q + {{AW{1'b0}}, ld_push} - {{AW{1'b0}}, gnt_ld};
            if (gnt_alu) last_ld_q <= 1'b0;
            else if (gnt_ld) last_ld_q <= 1'b1;
        end
    end

`ifdef WB_ARBITER_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_cnt} + 17'(alu_drop) + 17'(ld_drop);

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            wb_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (!wren && !(&wb_cnt)) wb_cnt <= wb_cnt + 1'b1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based reference model, plus directed scenarios.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstd;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_wa, ld_wa;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready;
    logic [31:0] wr;
    logic [4:0]  wa;
    logic        wren;
    logic [31:0] pend;
    logic        idle;
`ifdef WB_ARBITER_STATS_EN
    logic [31:0] wb_cnt;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rstd      (rstd),
        .alu_valid (alu_valid),
        .alu_wa    (alu_wa),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_wa     (ld_wa),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .wr        (wr),
        .wa        (wa),
        .wren      (wren),
        .pend      (pend),
        .idle      (idle)
`ifdef WB_ARBITER_STATS_EN
        ,
        .wb_cnt    (wb_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] data;
    } ent_t;

    ent_t        aq[$];
    ent_t        lq[$];
    bit          last_ld;
    logic [31:0] wb_m;
    logic [15:0] drop_m;
    logic [4:0]  issued[$];
    int          total = 0;
    int          bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 = no grant, 1 = ALU, 2 = load
    function automatic int exp_grant();
        if (aq.size() > 0 && lq.size() > 0) return last_ld ? 1 : 2;
        if (aq.size() > 0) return 1;
        if (lq.size() > 0) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        aq.delete();
        lq.delete();
        last_ld = 1'b0;
        wb_m    = '0;
        drop_m  = '0;
    endtask

    task automatic compare_all();
        int          g;
        logic [31:0] p;
        ent_t        h;
        g = exp_grant();
        p = '0;
        foreach (aq[i]) p[aq[i].wa] = 1'b1;
        foreach (lq[i]) p[lq[i].wa] = 1'b1;
        h = '0;
        if (g == 1) h = aq[0];
        if (g == 2) h = lq[0];
        check_eq("wren", wren, (g == 0));
        check_eq("wa", wa, h.wa);
        check_eq("wr", wr, h.data);
        check_eq("pend", pend, p);
        check_eq("idle", idle, (aq.size() == 0 && lq.size() == 0));
        check_eq("alu_ready", alu_ready, (aq.size() < DEPTH));
        check_eq("ld_ready", ld_ready, (lq.size() < DEPTH));
`ifdef WB_ARBITER_STATS_EN
        check_eq("wb_cnt", wb_cnt, wb_m);
        check_eq("drop_cnt", drop_cnt, drop_m);
`endif
        if (wren === 1'b0) issued.push_back(wa);
    endtask

    // Called just after a negedge: drive inputs, advance the model, then sample at the next negedge.
    task automatic step(input bit av, input logic [4:0] awa, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lwa, input logic [31:0] ldd);
        int g;
        bit ar, lr;
        alu_valid = av;
        alu_wa    = awa;
        alu_data  = ad;
        ld_valid  = lv;
        ld_wa     = lwa;
        ld_data   = ldd;
        g  = exp_grant();
        ar = aq.size() < DEPTH;
        lr = lq.size() < DEPTH;
        if (g == 1) begin
            void'(aq.pop_front());
            last_ld = 1'b0;
        end else if (g == 2) begin
            void'(lq.pop_front());
            last_ld = 1'b1;
        end
        if (g != 0 && wb_m != 32'hFFFF_FFFF) wb_m++;
        if (av && ar) begin
            if (awa != 0) aq.push_back('{wa: awa, data: ad});
            else if (drop_m != 16'hFFFF) drop_m++;
        end
        if (lv && lr) begin
            if (lwa != 0) lq.push_back('{wa: lwa, data: ldd});
            else if (drop_m != 16'hFFFF) drop_m++;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    function automatic logic [4:0] rand_wa();
        if ($urandom_range(0, 7) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic step_rand(input int pa, input int pl);
        step($urandom_range(0, 99) < pa, rand_wa(), $urandom,
             $urandom_range(0, 99) < pl, rand_wa(), $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wren"}, wren, 1'b1);
        check_eq({tag, "_wa"}, wa, 5'd0);
        check_eq({tag, "_wr"}, wr, 32'd0);
        check_eq({tag, "_pend"}, pend, 32'd0);
        check_eq({tag, "_idle"}, idle, 1'b1);
        check_eq({tag, "_alu_ready"}, alu_ready, 1'b1);
        check_eq({tag, "_ld_ready"}, ld_ready, 1'b1);
`ifdef WB_ARBITER_STATS_EN
        check_eq({tag, "_wb_cnt"}, wb_cnt, 32'd0);
        check_eq({tag, "_drop_cnt"}, drop_cnt, 16'd0);
`endif
    endtask

    initial begin
        logic [4:0] exp_ord[6];
        logic [31:0] wb_before;
        exp_ord = '{5'd11, 5'd1, 5'd12, 5'd2, 5'd13, 5'd3};

        rstd      = 1'b1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        alu_wa    = '0;
        ld_wa     = '0;
        alu_data  = '0;
        ld_data   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstd = 1'b0;
        compare_all();

        // Single ALU write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check_eq("single_wren", wren, 1'b0);
        check_eq("single_wa", wa, 5'd5);
        check_eq("single_wr", wr, 32'hDEADBEEF);
        check_eq("single_pend5", pend[5], 1'b1);
        idle_step();
        check_eq("single_done_wren", wren, 1'b1);
        check_eq("single_done_pend", pend, 32'd0);
        check_eq("single_done_idle", idle, 1'b1);

        // Contention: load wins first since the last grant was ALU
        issued.delete();
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(1 + i), $urandom, 1'b1, 5'(11 + i), $urandom);
        repeat (4) idle_step();
        check_eq("contention_count", issued.size(), 6);
        for (int i = 0; i < 6 && i < issued.size(); i++)
            check_eq($sformatf("contention_order%0d", i), issued[i], exp_ord[i]);

        // Register 0 is dropped
        step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
        check_eq("r0_wren", wren, 1'b1);
        check_eq("r0_pend0", pend[0], 1'b0);
`ifdef WB_ARBITER_STATS_EN
        check_eq("r0_drop_cnt", drop_cnt, 16'd1);
`endif

        // Wrap-around: ten back-to-back load writes
        issued.delete();
        wb_before = wb_m;
        for (int i = 1; i <= 10; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), $urandom);
        repeat (2) idle_step();
        check_eq("wrap_count", issued.size(), 10);
        for (int i = 0; i < 10 && i < issued.size(); i++)
            check_eq($sformatf("wrap_order%0d", i), issued[i], 5'(i + 1));
        check_eq("wrap_wb_delta", wb_m - wb_before, 32'd10);

        // Full queue: both sources push every cycle, so queues fill and ready drops
        for (int i = 0; i < 12; i++)
            step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        check_eq("full_ld_ready", ld_ready, 1'b0);
        repeat (10) idle_step();

        // Randomized phases with varying pressure
        repeat (300) step_rand(50, 50);
        repeat (300) step_rand(95, 90);
        repeat (300) step_rand(20, 80);

        // Reset during activity
        repeat (6) step_rand(100, 100);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        #2 rstd = 1'b1;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        check_reset_outputs("midreset_held");
        rstd = 1'b0;
        compare_all();
        repeat (300) step_rand(60, 60);
        repeat (8) idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
